// File: rtl/lsu_mem_responder_if.sv
// Request/response bundle between the control unit, the load/store responder
// and the 64-bit data memory.
interface lsu_mem_responder_if;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        busy;
    logic        done;
    logic        fault;
    logic [63:0] rdata;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_wr;
    logic [63:0] mem_rdata;

    // master is the environment side: control unit plus memory read port
    modport master (
        output req, we, funct3, addr, wdata, mem_rdata,
        input  busy, done, fault, rdata, mem_addr, mem_wdata, mem_wr
    );

    modport slave (
        input  req, we, funct3, addr, wdata, mem_rdata,
        output busy, done, fault, rdata, mem_addr, mem_wdata, mem_wr
    );
endinterface

// File: rtl/lsu_mem_responder.sv
// Sized RISC-V load/store responder for a 64-bit little-endian data memory;
// sub-doubleword stores use read-modify-write, loads are sign/zero extended.
module lsu_mem_responder (
    input  logic                  clk,
    input  logic                  reset,
    lsu_mem_responder_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        MERGE,
        WR,
        DONE
    } state_t;

    state_t      state;
    state_t      next_state;

    logic        we_q;
    logic [2:0]  funct3_q;
    logic [2:0]  off_q;
    logic [63:0] wdata_q;
    logic        fault_q;
    logic [63:0] rdata_q;
    logic [63:0] mem_addr_q;
    logic [63:0] mem_wdata_q;

    logic        misaligned;
    logic        illegal;
    logic        bad_req;
    logic        is_sd;
    logic [5:0]  shamt;
    logic [63:0] lane_mask;
    logic [63:0] lane_data;
    logic [63:0] merged;
    logic [63:0] load_val;

    // Acceptance-time checks operate on the live request inputs.
    always_comb begin
        misaligned = 1'b0;
        case (bus.funct3[1:0])
            2'b01:   misaligned = bus.addr[0];
            2'b10:   misaligned = (bus.addr[1:0] != 2'b00);
            2'b11:   misaligned = (bus.addr[2:0] != 3'b000);
            default: misaligned = 1'b0;
        endcase
        illegal = (bus.funct3 == 3'b111) || (bus.we && bus.funct3[2]);
        bad_req = misaligned || illegal;
        is_sd   = bus.we && (bus.funct3 == 3'b011);
    end

    // Lane extraction and merge for the latched access.
    always_comb begin
        shamt = {off_q, 3'b000};
        case (funct3_q[1:0])
            2'b00:   lane_mask = 64'h0000_0000_0000_00FF;
            2'b01:   lane_mask = 64'h0000_0000_0000_FFFF;
            2'b10:   lane_mask = 64'h0000_0000_FFFF_FFFF;
            default: lane_mask = '1;
        endcase
        lane_data = bus.mem_rdata >> shamt;
        merged    = (bus.mem_rdata & ~(lane_mask << shamt))
                  | ((wdata_q & lane_mask) << shamt);
    end

    always_comb begin
        load_val = lane_data;
        case (funct3_q)
            3'b000:  load_val = {{56{lane_data[7]}},  lane_data[7:0]};
            3'b001:  load_val = {{48{lane_data[15]}}, lane_data[15:0]};
            3'b010:  load_val = {{32{lane_data[31]}}, lane_data[31:0]};
            3'b100:  load_val = {56'd0, lane_data[7:0]};
            3'b101:  load_val = {48'd0, lane_data[15:0]};
            3'b110:  load_val = {32'd0, lane_data[31:0]};
            default: load_val = lane_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    if (bad_req) begin
                        next_state = DONE;
                    end else if (is_sd) begin
                        next_state = WR;
                    end else begin
                        next_state = RD;
                    end
                end
            end
            RD:      next_state = we_q ? MERGE : CAP;
            CAP:     next_state = DONE;
            MERGE:   next_state = WR;
            WR:      next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q        <= 1'b0;
            funct3_q    <= '0;
            off_q       <= '0;
            wdata_q     <= '0;
            fault_q     <= 1'b0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        we_q       <= bus.we;
                        funct3_q   <= bus.funct3;
                        off_q      <= bus.addr[2:0];
                        wdata_q    <= bus.wdata;
                        fault_q    <= bad_req;
                        mem_addr_q <= {bus.addr[63:3], 3'b000};
                        if (is_sd && !bad_req) begin
                            mem_wdata_q <= bus.wdata;
                        end
                    end
                end
                CAP:     rdata_q     <= load_val;
                MERGE:   mem_wdata_q <= merged;
                default: ;
            endcase
        end
    end

    // Write strobe is gated by reset so an abandoned store never lands.
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.fault     = (state == DONE) && fault_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wr    = (state == WR) && !reset;

endmodule
